// File: rtl/hci_prio_scheduler.sv
// hci_prio_scheduler: picks TCDM arbitration priority between the core (log)
// branch and the HWPE branch. Modes: fixed core, fixed HWPE, time-sliced, and
// adaptive (HWPE gets a bounded slice after starving cfg_max_stall_i cycles).
// Optional statistics counters are built when HCI_PRIO_SCHED_STATS_EN is defined;
// otherwise the statistics outputs are tied to 0.
module hci_prio_scheduler #(
    parameter int unsigned N_CORE  = 8,
    parameter int unsigned N_HWPE  = 1,
    parameter int unsigned STALL_W = 8,
    parameter int unsigned SLICE_W = 16,
    parameter int unsigned STAT_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               cfg_en_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [STALL_W-1:0] cfg_max_stall_i,
    input  logic [SLICE_W-1:0] cfg_slice_i,
    input  logic [N_CORE-1:0]  core_req_i,
    input  logic [N_CORE-1:0]  core_gnt_i,
    input  logic [N_HWPE-1:0]  hwpe_req_i,
    input  logic [N_HWPE-1:0]  hwpe_gnt_i,
    output logic               invert_prio_o,
    output logic [1:0]         state_o,
    output logic [STAT_W-1:0]  switch_cnt_o,
    output logic [STAT_W-1:0]  core_stall_cnt_o,
    output logic [STAT_W-1:0]  hwpe_stall_cnt_o
);

    // Bit 1 of the encoding is set exactly in the HWPE-priority states.
    typedef enum logic [1:0] {
        ST_DIS  = 2'b00,
        ST_CORE = 2'b01,
        ST_HWPE = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    localparam logic [SLICE_W-1:0] SLICE_ONE = SLICE_W'(1);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    state_e             state_q, state_d;
    logic [1:0]         mode_q;
    logic [STALL_W-1:0] stall_run_q, stall_run_d;
    logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
    logic               invert_q;

    logic               core_stall, hwpe_stall, hwpe_busy;
    logic [SLICE_W-1:0] eff_slice;
    logic               slice_last;
    state_e             start_state;

    assign core_stall  = |(core_req_i & ~core_gnt_i);
    assign hwpe_stall  = |(hwpe_req_i & ~hwpe_gnt_i);
    assign hwpe_busy   = |hwpe_req_i;
    assign eff_slice   = (cfg_slice_i == '0) ? SLICE_ONE : cfg_slice_i;
    // >= so that shrinking the slice mid-run still terminates the current slice.
    assign slice_last  = (slice_cnt_q >= (eff_slice - SLICE_ONE));
    assign start_state = (cfg_mode_i == 2'd1) ? ST_HWPE : ST_CORE;

    // Next-state logic; disable beats mode change beats slice/threshold events.
    always_comb begin
        state_d     = state_q;
        stall_run_d = stall_run_q;
        slice_cnt_d = slice_cnt_q;
        if (!cfg_en_i) begin
            state_d     = ST_DIS;
            stall_run_d = '0;
            slice_cnt_d = '0;
        end else if (state_q == ST_DIS || cfg_mode_i != mode_q) begin
            state_d     = start_state;
            stall_run_d = '0;
            slice_cnt_d = '0;
        end else begin
            case (state_q)
                ST_CORE: begin
                    if (cfg_mode_i == 2'd2) begin
                        if (slice_last) begin
                            state_d     = ST_HWPE;
                            slice_cnt_d = '0;
                        end else begin
                            slice_cnt_d = slice_cnt_q + SLICE_ONE;
                        end
                    end else if (cfg_mode_i == 2'd3) begin
                        if (!hwpe_stall) begin
                            stall_run_d = '0;
                        end else if (cfg_max_stall_i != '0 &&
                                     (stall_run_q + STALL_ONE) == cfg_max_stall_i) begin
                            state_d     = ST_HOLD;
                            stall_run_d = '0;
                            slice_cnt_d = '0;
                        end else if (stall_run_q != '1) begin
                            stall_run_d = stall_run_q + STALL_ONE;
                        end
                    end
                end
                ST_HWPE: begin
                    if (cfg_mode_i == 2'd2) begin
                        if (slice_last) begin
                            state_d     = ST_CORE;
                            slice_cnt_d = '0;
                        end else begin
                            slice_cnt_d = slice_cnt_q + SLICE_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!hwpe_busy || slice_last) begin
                        state_d     = ST_CORE;
                        slice_cnt_d = '0;
                        stall_run_d = '0;
                    end else begin
                        slice_cnt_d = slice_cnt_q + SLICE_ONE;
                    end
                end
                default: state_d = ST_DIS;
            endcase
        end
    end

    // State, counters and the registered priority bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_DIS;
            mode_q      <= 2'd0;
            stall_run_q <= '0;
            slice_cnt_q <= '0;
            invert_q    <= 1'b0;
        end else if (clear_i) begin
            state_q     <= ST_DIS;
            mode_q      <= 2'd0;
            stall_run_q <= '0;
            slice_cnt_q <= '0;
            invert_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= cfg_mode_i;
            stall_run_q <= stall_run_d;
            slice_cnt_q <= slice_cnt_d;
            invert_q    <= state_d[1];
        end
    end

    assign invert_prio_o = invert_q;
    assign state_o       = state_q;

`ifdef HCI_PRIO_SCHED_STATS_EN
    logic [STAT_W-1:0] switch_cnt_q, core_stall_cnt_q, hwpe_stall_cnt_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // Saturating statistics; stall counters run in every state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            switch_cnt_q     <= '0;
            core_stall_cnt_q <= '0;
            hwpe_stall_cnt_q <= '0;
        end else if (clear_i) begin
            switch_cnt_q     <= '0;
            core_stall_cnt_q <= '0;
            hwpe_stall_cnt_q <= '0;
        end else begin
            if (state_d[1] != invert_q) switch_cnt_q <= sat_inc(switch_cnt_q);
            if (core_stall) core_stall_cnt_q <= sat_inc(core_stall_cnt_q);
            if (hwpe_stall) hwpe_stall_cnt_q <= sat_inc(hwpe_stall_cnt_q);
        end
    end

    assign switch_cnt_o     = switch_cnt_q;
    assign core_stall_cnt_o = core_stall_cnt_q;
    assign hwpe_stall_cnt_o = hwpe_stall_cnt_q;
`else
    logic unused_core_stall;
    assign unused_core_stall = core_stall;
    assign switch_cnt_o      = '0;
    assign core_stall_cnt_o  = '0;
    assign hwpe_stall_cnt_o  = '0;
`endif

endmodule

// File: doc/hci_prio_scheduler.md
Name: hci_prio_scheduler

Overview:
- Sequences the TCDM arbitration priority between the core-side (log) branch and the HWPE-side branch of the heterogeneous interconnect.
- Observes per-port request/grant activity and drives the priority-inversion control bit that feeds the interconnect control input.
- Modes: fixed, time-sliced, or adaptive.
  - Adaptive mode hands priority to the HWPE branch once it starves for a programmable number of cycles.
  - It then returns priority to the cores after a bounded slice.

Parameters:
- N_CORE, 8, number of core-side request ports observed.
- N_HWPE, 1, number of HWPE-side request ports observed.
- STALL_W, 8, width of the stall threshold and stall run counter.
- SLICE_W, 16, width of the slice length and slice counter.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  cluster clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of FSM, counters and outputs to reset values.
- cfg_en_i  in  1  scheduler enable; 0 forces core priority.
- cfg_mode_i  in  2  0 = fixed core prio, 1 = fixed HWPE prio, 2 = time-sliced, 3 = adaptive.
- cfg_max_stall_i  in  STALL_W  adaptive starvation threshold in cycles.
- cfg_slice_i  in  SLICE_W  slice length in cycles.
- core_req_i  in  N_CORE  core TCDM requests.
- core_gnt_i  in  N_CORE  core TCDM grants.
- hwpe_req_i  in  N_HWPE  HWPE TCDM requests.
- hwpe_gnt_i  in  N_HWPE  HWPE TCDM grants.
- invert_prio_o  out  1  1 = HWPE branch has priority.
- state_o  out  2  current FSM state encoding.
- switch_cnt_o  out  STAT_W  number of priority changes.
- core_stall_cnt_o  out  STAT_W  cycles with any core req && !gnt.
- hwpe_stall_cnt_o  out  STAT_W  cycles with any HWPE req && !gnt.

Behaviour:
- Reset values (async, and also on clear_i): state = DISABLED (2'b00), all counters 0, all outputs 0.
- Definitions:
  - core_stall = |(core_req_i & ~core_gnt_i).
  - hwpe_stall = |(hwpe_req_i & ~hwpe_gnt_i).
  - hwpe_busy = |hwpe_req_i.
- States: DISABLED = 00, CORE_PRIO = 01, HWPE_PRIO = 10, HOLD = 11 (HWPE prio during an adaptive slice).
- invert_prio_o is registered: it equals (state == HWPE_PRIO || state == HOLD), updated in the same edge as the state. The interconnect sees the new priority one cycle after the triggering condition is sampled.
- State transitions:
  - DISABLED: if cfg_en_i, go to CORE_PRIO when mode is 0, 2 or 3; go to HWPE_PRIO when mode is 1.
  - Any state with !cfg_en_i: go to DISABLED next cycle; slice and stall counters cleared.
  - Mode change while enabled (cfg_mode_i differs from the registered copy): go to CORE_PRIO (or HWPE_PRIO for mode 1) next cycle; slice and stall counters cleared.
  - Mode 2: CORE_PRIO <-> HWPE_PRIO, toggling each time slice_cnt reaches eff_slice-1; slice_cnt resets to 0 on each toggle.
  - Mode 3, CORE_PRIO:
    - stall_run increments on hwpe_stall and resets to 0 on a cycle without hwpe_stall.
    - When stall_run+1 == cfg_max_stall_i with hwpe_stall, go to HOLD; stall_run is cleared.
    - cfg_max_stall_i == 0 disables adaptive switching (stay in CORE_PRIO).
  - Mode 3, HOLD: slice_cnt increments each cycle. Exit to CORE_PRIO when slice_cnt reaches eff_slice-1 OR !hwpe_busy, whichever comes first.
- eff_slice = (cfg_slice_i == 0) ? 1 : cfg_slice_i.
- switch_cnt_o increments on each edge where invert_prio_o changes value. This includes changes on entry to and exit from DISABLED.
- All counters saturate at all-ones; no wrap.
- Simultaneous events, in priority order: clear_i > !cfg_en_i > mode change > threshold/slice event.
- Stall counters count every cycle regardless of state, including DISABLED.

Optional Feature:
- Macro: HCI_PRIO_SCHED_STATS_EN.
- Defined: switch_cnt_o, core_stall_cnt_o and hwpe_stall_cnt_o are implemented as described.
- Undefined: the three statistics outputs are tied to 0 and no statistics registers are instantiated. FSM and invert_prio_o behaviour are identical in both builds.

Test Plan:
- Reset and enable: rst_ni low then high, cfg_en_i=1, mode=0 -> state_o=01 one cycle after enable, invert_prio_o stays 0, switch_cnt_o=0.
- Time slice: mode=2, cfg_slice_i=4, no traffic -> invert_prio_o toggles every 4 cycles; switch_cnt_o=5 after 20 cycles.
- Adaptive trigger: mode=3, cfg_max_stall_i=3, cfg_slice_i=8, hwpe_req=1 with gnt=0 held -> invert_prio_o rises on the 4th edge and drops after 8 cycles in HOLD.
- Early exit and interrupted stall run:
  - In HOLD, drop hwpe_req_i at slice cycle 2 -> CORE_PRIO next cycle.
  - Stall run of 2 then one granted cycle -> no switch.
- Boundaries:
  - cfg_max_stall_i=0 with permanent HWPE stall -> never leaves CORE_PRIO.
  - cfg_slice_i=0 in mode 2 -> toggles every cycle.
  - Forcing counters near all-ones -> they saturate.
- Mid-operation disruption:
  - Assert clear_i while in HOLD -> all outputs 0 next cycle.
  - Deassert cfg_en_i while in HWPE_PRIO -> DISABLED, invert_prio_o=0, switch_cnt_o increments by 1.
